// File: rtl/rv32_lsu_wb_bridge_pkg.sv
// Shared types and helpers for the rv32 load/store to Wishbone bridge.
package rv_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    // Natural alignment only; unsigned loads have no store counterpart.
    function automatic logic legal_access(input logic [2:0] op,
                                          input logic [1:0] addr_lo,
                                          input logic       we);
        logic ok;
        case (op)
            OP_B:    ok = 1'b1;
            OP_H:    ok = ~addr_lo[0];
            OP_W:    ok = (addr_lo == 2'b00);
            OP_BU:   ok = ~we;
            OP_HU:   ok = ~we & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rv32_lsu_wb_bridge_lane_align.sv
// Byte-lane steering: store replication, byte enables and load extraction/extension.
module lsu_lane_align
    import rv_lsu_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int SEL_WIDTH  = DATA_WIDTH / 8,
    localparam int IDX_WIDTH  = $clog2(SEL_WIDTH)
) (
    input  logic [2:0]            op_i,
    input  logic [IDX_WIDTH-1:0]  idx_i,
    input  logic [31:0]           wdata_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [SEL_WIDTH-1:0]  sel_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic [31:0]           load_o
);

    logic [DATA_WIDTH-1:0] lane_s;

    assign lane_s = rdata_i >> {idx_i, 3'b000};

    // Byte enables and replicated store data from the access size.
    always_comb begin
        sel_o = '0;
        dat_o = '0;
        case (op_i[1:0])
            2'b00: begin
                sel_o = SEL_WIDTH'(4'h1) << idx_i;
                dat_o = {SEL_WIDTH{wdata_i[7:0]}};
            end
            2'b01: begin
                sel_o = SEL_WIDTH'(4'h3) << idx_i;
                dat_o = {(DATA_WIDTH / 16){wdata_i[15:0]}};
            end
            2'b10: begin
                sel_o = SEL_WIDTH'(4'hF) << idx_i;
                dat_o = {(DATA_WIDTH / 32){wdata_i}};
            end
            default: begin
                sel_o = '0;
                dat_o = '0;
            end
        endcase
    end

    // Load result taken from the addressed lane and extended to 32 bits.
    always_comb begin
        load_o = 32'd0;
        case (op_i)
            OP_B:    load_o = {{24{lane_s[7]}}, lane_s[7:0]};
            OP_H:    load_o = {{16{lane_s[15]}}, lane_s[15:0]};
            OP_W:    load_o = lane_s[31:0];
            OP_BU:   load_o = {24'd0, lane_s[7:0]};
            OP_HU:   load_o = {16'd0, lane_s[15:0]};
            default: load_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/rv32_lsu_wb_bridge.sv
// MEM-stage load/store bridge to a Wishbone classic master, with pipeline stall,
// alignment checking, bus-error capture and a REQ-phase timeout.
module rv32_lsu_wb_bridge
    import rv_lsu_pkg::*;
#(
    parameter  int ADDR_WIDTH     = 32,
    parameter  int DATA_WIDTH     = 32,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int SEL_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           mem_addr_mem,
    input  logic [31:0]           mem_wdata_mem,
    input  logic                  mem_write_mem,
    input  logic                  mem_read_mem,
    input  logic [2:0]            mem_op_mem,
    output logic [31:0]           mem_rdata_mem,
    output logic                  stall_pipl,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic [SEL_WIDTH-1:0]  wb_sel_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    output logic                  addr_err,
    output logic                  bus_err,
    output logic                  timeout_err
);

    localparam int IDX_WIDTH = $clog2(SEL_WIDTH);
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [2:0]            op_q;
    logic                  we_q;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  bus_err_q, bus_err_d;
    logic                  timeout_err_q, timeout_err_d;

    logic                  req_s, legal_s, latch_s, stall_s, addr_err_s, in_req_s;
    logic [SEL_WIDTH-1:0]  sel_s;
    logic [DATA_WIDTH-1:0] dat_s;
    logic [31:0]           load_s;

    assign req_s   = mem_read_mem | mem_write_mem;
    assign legal_s = legal_access(mem_op_mem, mem_addr_mem[1:0], mem_write_mem);

    lsu_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .op_i    (op_q),
        .idx_i   (addr_q[IDX_WIDTH-1:0]),
        .wdata_i (wdata_q),
        .rdata_i (wb_dat_i),
        .sel_o   (sel_s),
        .dat_o   (dat_s),
        .load_o  (load_s)
    );

    // Next-state, stall and error decisions; a bus error beats a same-cycle ack.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        bus_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        latch_s       = 1'b0;
        stall_s       = 1'b0;
        addr_err_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s && legal_s) begin
                    stall_s = 1'b1;
                    latch_s = 1'b1;
                    state_d = REQ;
                end else if (req_s) begin
                    addr_err_s = 1'b1;
                end else begin
                    stall_s = 1'b0;
                end
            end
            REQ: begin
                stall_s = 1'b1;
                if (wb_err_i) begin
                    bus_err_d = 1'b1;
                    rdata_d   = 32'd0;
                    state_d   = DONE;
                end else if (wb_ack_i) begin
                    rdata_d = load_s;
                    state_d = DONE;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    timeout_err_d = 1'b1;
                    rdata_d       = 32'd0;
                    state_d       = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1'b1);
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, result and latched request registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rdata_q       <= 32'd0;
            bus_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= 32'd0;
            op_q          <= 3'd0;
            we_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rdata_q       <= rdata_d;
            bus_err_q     <= bus_err_d;
            timeout_err_q <= timeout_err_d;
            if (latch_s) begin
                addr_q  <= mem_addr_mem[ADDR_WIDTH-1:0];
                wdata_q <= mem_wdata_mem;
                op_q    <= mem_op_mem;
                we_q    <= mem_write_mem;
            end
        end
    end

    assign in_req_s = (state_q == REQ);

    assign wb_cyc_o      = in_req_s;
    assign wb_stb_o      = in_req_s;
    assign wb_we_o       = in_req_s & we_q;
    assign wb_adr_o      = {addr_q[ADDR_WIDTH-1:IDX_WIDTH], {IDX_WIDTH{1'b0}}};
    assign wb_sel_o      = in_req_s ? sel_s : '0;
    assign wb_dat_o      = dat_s;
    // Combinational stall/addr_err are forced low while reset is held.
    assign stall_pipl    = reset_n & stall_s;
    assign addr_err      = reset_n & addr_err_s;
    assign mem_rdata_mem = addr_err_s ? 32'd0 : rdata_q;
    assign bus_err       = bus_err_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_rv32_lsu_wb_bridge.sv
// Scoreboard bench: 64-bit and 32-bit bridges run in lockstep from one core stream.
module tb_rv32_lsu_wb_bridge;
    localparam int TO = 4;

    typedef struct {
        bit          illegal;
        bit          we;
        bit          chk_rd;
        logic [31:0] rdata;
        int          ncyc;
        bit          berr;
        bit          terr;
        logic [31:0] adr0, adr1;
        logic [7:0]  sel0, sel1;
        logic [63:0] dat0, dat1;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] mem_addr_mem, mem_wdata_mem;
    logic        mem_write_mem, mem_read_mem;
    logic [2:0]  mem_op_mem;
    logic        ack_s, err_s;
    logic [63:0] p_d64;
    logic [31:0] p_addr;
    int          p_lat, p_kind;
    logic [63:0] dat64_i;
    logic [31:0] dat32_i;

    logic [31:0] rd64, rd32, adr64, adr32;
    logic [63:0] dato64;
    logic [31:0] dato32;
    logic [7:0]  sel64;
    logic [3:0]  sel32;
    logic [1:0]  cyc_v, stb_v, we_v, stall_v, ae_v, be_v, te_v;
    logic [31:0] rd_v  [2];
    logic [31:0] adr_v [2];
    logic [7:0]  sel_v [2];
    logic [63:0] dat_v [2];

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    assign dat64_i = p_d64;
    assign dat32_i = p_addr[2] ? p_d64[63:32] : p_d64[31:0];
    assign rd_v[0] = rd64;   assign rd_v[1] = rd32;
    assign adr_v[0] = adr64; assign adr_v[1] = adr32;
    assign sel_v[0] = sel64; assign sel_v[1] = {4'h0, sel32};
    assign dat_v[0] = dato64; assign dat_v[1] = {32'h0, dato32};

    rv32_lsu_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(TO)) u64 (
        .clk(clk), .reset_n(reset_n), .mem_addr_mem(mem_addr_mem), .mem_wdata_mem(mem_wdata_mem),
        .mem_write_mem(mem_write_mem), .mem_read_mem(mem_read_mem), .mem_op_mem(mem_op_mem),
        .mem_rdata_mem(rd64), .stall_pipl(stall_v[0]), .wb_cyc_o(cyc_v[0]), .wb_stb_o(stb_v[0]),
        .wb_we_o(we_v[0]), .wb_adr_o(adr64), .wb_dat_o(dato64), .wb_sel_o(sel64), .wb_dat_i(dat64_i),
        .wb_ack_i(ack_s), .wb_err_i(err_s), .addr_err(ae_v[0]), .bus_err(be_v[0]), .timeout_err(te_v[0]));

    rv32_lsu_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) u32 (
        .clk(clk), .reset_n(reset_n), .mem_addr_mem(mem_addr_mem), .mem_wdata_mem(mem_wdata_mem),
        .mem_write_mem(mem_write_mem), .mem_read_mem(mem_read_mem), .mem_op_mem(mem_op_mem),
        .mem_rdata_mem(rd32), .stall_pipl(stall_v[1]), .wb_cyc_o(cyc_v[1]), .wb_stb_o(stb_v[1]),
        .wb_we_o(we_v[1]), .wb_adr_o(adr32), .wb_dat_o(dato32), .wb_sel_o(sel32), .wb_dat_i(dat32_i),
        .wb_ack_i(ack_s), .wb_err_i(err_s), .addr_err(ae_v[1]), .bus_err(be_v[1]), .timeout_err(te_v[1]));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        n_chk++;
        if (got !== req) $display("FAIL %s: got 0x%0h required 0x%0h", name, got, req);
        else n_pass++;
    endtask

    function automatic bit legal_model(input logic [2:0] op, input logic [31:0] a, input bit we);
        int nb;
        if (op == 3'b011 || op[2:1] == 2'b11) return 1'b0;
        if (op[2] && we) return 1'b0;
        nb = 1 << op[1:0];
        return (a % nb) == 0;
    endfunction

    function automatic logic [31:0] load_model(input logic [63:0] d, input logic [31:0] a,
                                               input logic [2:0] op);
        longint unsigned v;
        int nb;
        nb = 1 << op[1:0];
        v = (d >> (8 * a[2:0])) & ((64'd1 << (8 * nb)) - 64'd1);
        if (!op[2] && nb < 4 && v[8 * nb - 1]) v = v - (64'd1 << (8 * nb));
        return v[31:0];
    endfunction

    // w = bus width in bytes; lane j carries store byte (j mod access size)
    function automatic void bus_model(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] op,
                                      input int w, output logic [31:0] adr, output logic [7:0] sel,
                                      output logic [63:0] dat);
        int sz, idx;
        sz  = 1 << op[1:0];
        idx = int'(a[2:0]) % w;
        adr = a - 32'(idx);
        sel = 8'h00;
        dat = 64'h0;
        for (int j = 0; j < w; j++) begin
            if (j >= idx && j < idx + sz) sel[j] = 1'b1;
            dat[8*j +: 8] = wd[8*(j % sz) +: 8];
        end
    endfunction

    // kind: 0 ack, 1 err, 2 err+ack, 3 silent slave; response in REQ cycle lat+1
    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input bit rd, input bit wr,
                         input logic [2:0] op, input int lat, input int kind, input logic [63:0] d);
        exp_t e;
        int resp_at, n;
        resp_at   = (kind == 3) ? 1000 : lat + 1;
        e.illegal = !legal_model(op, a, wr);
        e.we      = wr;
        e.terr    = !e.illegal && resp_at > TO;
        e.ncyc    = e.illegal ? 0 : (e.terr ? TO : resp_at);
        e.berr    = !e.illegal && !e.terr && (kind == 1 || kind == 2);
        e.chk_rd  = e.illegal || !wr || e.berr || e.terr;
        e.rdata   = (e.illegal || e.berr || e.terr) ? 32'h0 : load_model(d, a, op);
        bus_model(a, wd, op, 8, e.adr0, e.sel0, e.dat0);
        bus_model(a, wd, op, 4, e.adr1, e.sel1, e.dat1);
        exp_q.push_back(e);
        p_d64 = d; p_addr = a; p_lat = lat; p_kind = kind;
        mem_addr_mem = a; mem_wdata_mem = wd; mem_op_mem = op;
        mem_read_mem = rd; mem_write_mem = wr;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall_v[0] && n < 40);
        if (stall_v[0]) chk("stall_release", 64'(stall_v[0]), 64'd0);
        @(posedge clk); #1;
        mem_read_mem = 1'b0; mem_write_mem = 1'b0;
    endtask

    // Wishbone slave: counts REQ cycles and answers per the current plan
    initial begin : slave
        int rc;
        rc = 0; ack_s = 1'b0; err_s = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc_v[0]) rc++;
            else rc = 0;
            ack_s = cyc_v[0] && p_kind != 3 && rc == p_lat + 1 && (p_kind == 0 || p_kind == 2);
            err_s = cyc_v[0] && p_kind != 3 && rc == p_lat + 1 && (p_kind == 1 || p_kind == 2);
        end
    end

    // Monitor: bus fields every REQ cycle, full transaction result at DONE / addr_err
    initial begin : monitor
        exp_t e;
        int cyc_n[2], stall_n[2], be_n[2], te_n[2], ae_n[2];
        bit prev_cyc;
        prev_cyc = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc_n[i] = 0; stall_n[i] = 0; be_n[i] = 0; te_n[i] = 0; ae_n[i] = 0;
        end
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_q.delete();
                prev_cyc = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    cyc_n[i] = 0; stall_n[i] = 0; be_n[i] = 0; te_n[i] = 0; ae_n[i] = 0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    cyc_n[i] += int'(cyc_v[i]); stall_n[i] += int'(stall_v[i]);
                    be_n[i] += int'(be_v[i]); te_n[i] += int'(te_v[i]); ae_n[i] += int'(ae_v[i]);
                end
                if (cyc_v[0] && exp_q.size() > 0) begin
                    e = exp_q[0];
                    for (int i = 0; i < 2; i++) begin
                        chk($sformatf("stb[%0d]", i), 64'(stb_v[i]), 64'd1);
                        chk($sformatf("stall_req[%0d]", i), 64'(stall_v[i]), 64'd1);
                        chk($sformatf("we[%0d]", i), 64'(we_v[i]), 64'(e.we));
                        chk($sformatf("adr[%0d]", i), 64'(adr_v[i]), 64'(i == 0 ? e.adr0 : e.adr1));
                        chk($sformatf("sel[%0d]", i), 64'(sel_v[i]), 64'(i == 0 ? e.sel0 : e.sel1));
                        if (e.we) chk($sformatf("dat[%0d]", i), dat_v[i], i == 0 ? e.dat0 : e.dat1);
                    end
                end
                if ((prev_cyc && !cyc_v[0]) || ae_v != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_completion", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        for (int i = 0; i < 2; i++) begin
                            if (e.chk_rd) chk($sformatf("rdata[%0d]", i), 64'(rd_v[i]), 64'(e.rdata));
                            chk($sformatf("stall_end[%0d]", i), 64'(stall_v[i]), 64'd0);
                            chk($sformatf("addr_err[%0d]", i), 64'(ae_n[i]), 64'(e.illegal));
                            chk($sformatf("cyc_cycles[%0d]", i), 64'(cyc_n[i]), 64'(e.ncyc));
                            chk($sformatf("stall_cycles[%0d]", i), 64'(stall_n[i]),
                                64'(e.illegal ? 0 : e.ncyc + 1));
                            chk($sformatf("bus_err[%0d]", i), 64'(be_n[i]), 64'(e.berr));
                            chk($sformatf("timeout_err[%0d]", i), 64'(te_n[i]), 64'(e.terr));
                            cyc_n[i] = 0; stall_n[i] = 0; be_n[i] = 0; te_n[i] = 0; ae_n[i] = 0;
                        end
                    end
                end
                prev_cyc = cyc_v[0];
            end
        end
    end

    initial begin : driver
        logic [31:0] a, wd;
        logic [2:0]  op;
        int          r, kind, gap;
        reset_n = 1'b0;
        mem_addr_mem = 32'h0; mem_wdata_mem = 32'h0; mem_op_mem = 3'b000;
        mem_read_mem = 1'b0; mem_write_mem = 1'b0;
        p_d64 = 64'h0; p_addr = 32'h0; p_lat = 0; p_kind = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_cyc[%0d]", i), 64'(cyc_v[i]), 64'd0);
            chk($sformatf("rst_stall[%0d]", i), 64'(stall_v[i]), 64'd0);
            chk($sformatf("rst_rdata[%0d]", i), 64'(rd_v[i]), 64'd0);
            chk($sformatf("rst_errs[%0d]", i), 64'({ae_v[i], be_v[i], te_v[i]}), 64'd0);
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        issue(32'h0000_0103, 32'h0, 1'b1, 1'b0, 3'b000, 1, 0, 64'h1234_5678_80FF_0000);
        issue(32'h0000_2004, 32'hDEAD_BEEF, 1'b0, 1'b1, 3'b010, 0, 0, 64'h0);
        issue(32'h0000_0101, 32'h0, 1'b1, 1'b0, 3'b001, 0, 0, 64'h0);
        issue(32'h0000_0200, 32'h0, 1'b1, 1'b0, 3'b010, 0, 3, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(32'h0000_0204, 32'h0, 1'b1, 1'b0, 3'b010, 2, 0, 64'hCAFE_F00D_0BAD_BEEF);
        issue(32'h0000_0002, 32'h0, 1'b1, 1'b0, 3'b101, 0, 2, 64'h0000_0000_8001_0000);
        issue(32'h0000_0002, 32'h0, 1'b1, 1'b0, 3'b101, 0, 0, 64'h0000_0000_8001_0000);
        issue(32'h0000_0008, 32'h0, 1'b1, 1'b0, 3'b010, 3, 0, 64'h0000_0000_1111_2222);
        issue(32'h0000_000C, 32'h0, 1'b1, 1'b0, 3'b010, 4, 0, 64'h3333_4444_0000_0000);
        issue(32'h0000_0010, 32'h55, 1'b1, 1'b1, 3'b100, 0, 0, 64'h0);
        issue(32'h0000_0016, 32'hA5A5_1234, 1'b1, 1'b1, 3'b001, 1, 1, 64'h0);

        // reset in the middle of a REQ phase
        p_kind = 3; p_lat = 0; p_addr = 32'h40; p_d64 = 64'h0;
        mem_addr_mem = 32'h40; mem_op_mem = 3'b010; mem_read_mem = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_reset_cyc", 64'(cyc_v), 64'd3);
        #3 reset_n = 1'b0;
        #1;
        chk("async_cyc", 64'(cyc_v), 64'd0);
        chk("async_stb", 64'(stb_v), 64'd0);
        chk("async_stall", 64'(stall_v), 64'd0);
        mem_read_mem = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #3 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", 64'({cyc_v, stall_v}), 64'd0);
        issue(32'h0000_0013, 32'h0000_00A5, 1'b0, 1'b1, 3'b000, 0, 0, 64'h0);

        for (int t = 0; t < 300; t++) begin
            a  = $urandom;
            wd = $urandom;
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            r  = $urandom_range(1, 3);
            kind = $urandom_range(0, 9);
            kind = (kind < 6) ? 0 : kind - 6;
            issue(a, wd, r[0], r[1], op, $urandom_range(0, 5), kind, {$urandom, $urandom});
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rv32_lsu_wb_bridge.md
Name: rv32_lsu_wb_bridge

Overview:
- Parametrised load/store bridge between the rv32i core MEM-stage memory bus and a Wishbone classic master port.
- Generates the core's stall_pipl, so a bus access of any latency freezes the pipeline until it completes.
- Adds byte-lane selection, load sign/zero extension, alignment checking, bus-error capture and a transaction timeout.
- Bus width is generalised to 32 or 64 bits.

Parameters:
- ADDR_WIDTH, 32, width of wb_adr_o; core address is truncated to this width.
- DATA_WIDTH, 32, Wishbone data width; legal values are 32 and 64. SEL_WIDTH = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, maximum cycles in REQ before abort; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- mem_addr_mem  in  32  byte address from the MEM stage
- mem_wdata_mem  in  32  store data, right-aligned
- mem_write_mem  in  1  store request
- mem_read_mem  in  1  load request
- mem_op_mem  in  3  funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- mem_rdata_mem  out  32  extended load result
- stall_pipl  out  1  freezes the core pipeline while high
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_adr_o  out  ADDR_WIDTH  bus-aligned byte address (low log2(SEL_WIDTH) bits zero)
- wb_dat_o  out  DATA_WIDTH  store data replicated across lanes
- wb_sel_o  out  SEL_WIDTH  byte enables
- wb_dat_i  in  DATA_WIDTH  read data
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  bus error
- addr_err  out  1  one-cycle pulse: misaligned access or unsupported mem_op
- bus_err  out  1  one-cycle pulse: wb_err_i received
- timeout_err  out  1  one-cycle pulse: transaction aborted by the timeout

Behaviour:
- Reset: state IDLE; all outputs 0; latched request registers and timeout counter cleared. Reset asserted mid-transaction drops wb_cyc_o/wb_stb_o immediately.
- Request: mem_read_mem | mem_write_mem. If both are high, the write wins.
- Core contract: the core advances on every cycle in which stall_pipl = 0.
- IDLE:
  - Legal request: stall_pipl = 1 combinationally; latch addr, wdata, op and we; go to REQ.
  - Illegal request: no bus cycle; addr_err = 1 this cycle; stall_pipl = 0; mem_rdata_mem = 0; the store is dropped; stay in IDLE.
  - Illegal means: halfword with addr[0] = 1; word with addr[1:0] != 0; op 011/110/111; op 100/101 with a write.
  - No request: stall_pipl = 0.
- REQ:
  - wb_cyc_o = wb_stb_o = 1; wb_we_o, wb_adr_o, wb_sel_o and wb_dat_o come from the latched request and are stable for the whole cycle. stall_pipl = 1.
  - Each cycle: if wb_err_i, then bus_err = 1, rdata_q = 0, go to DONE (err wins over a simultaneous ack).
  - Else if wb_ack_i: rdata_q = extended load, go to DONE.
  - Else if the counter equals TIMEOUT_CYCLES-1 (timeout enabled): drop cyc/stb next cycle, timeout_err = 1, rdata_q = 0, go to DONE.
  - Otherwise: increment the counter.
- DONE: cyc/stb = 0; stall_pipl = 0; mem_rdata_mem = rdata_q; counter cleared; go to IDLE. Minimum access latency is 3 cycles (IDLE, REQ with ack, DONE).
- mem_rdata_mem holds rdata_q outside DONE. It is zeroed on an addr_err cycle.
- Lane index is addr[log2(SEL_WIDTH)-1:0].
- Byte access: sel = 1 << idx. Halfword: sel = 2'b11 << idx. Word: sel = 4'hF << idx.
- Stores: byte data is replicated to every byte lane; halfword data to every 16-bit lane; word data to every 32-bit lane.
- Loads extract from lane idx. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Back-to-back: a new request in the IDLE cycle directly after DONE starts immediately. There are no idle bubbles beyond DONE.

Decomposition:
- Package rv_lsu_pkg:
  - state enum {IDLE, REQ, DONE}
  - mem_op localparams (OP_B = 3'b000, OP_H = 3'b001, OP_W = 3'b010, OP_BU = 3'b100, OP_HU = 3'b101)
  - function legal_access(op, addr_lo, we)
- One combinational sub-module, lsu_lane_align, parametrised by DATA_WIDTH. It produces wb_sel_o, the replicated wb_dat_o and the extracted/extended load word. The FSM, timeout counter and stall logic stay in the top.

Test Plan:
- DATA_WIDTH=32, LB at 0x103; slave acks on the 2nd REQ cycle with dat_i 0x80FF_0000. Required: wb_sel_o = 4'b1000; stall high for 3 cycles; mem_rdata_mem = 0xFFFF_FF80 in DONE.
- DATA_WIDTH=64, SW 0xDEAD_BEEF at 0x2004. Required: wb_adr_o = 0x2000; wb_sel_o = 8'hF0; wb_dat_o = 0xDEAD_BEEF_DEAD_BEEF; wb_we_o = 1.
- LH at 0x101. Required: no wb_cyc_o; addr_err pulses 1 cycle; stall_pipl = 0; mem_rdata_mem = 0.
- TIMEOUT_CYCLES=4, LW with no ack. Required: cyc high exactly 4 cycles; timeout_err pulses; DONE returns 0; next request proceeds normally.
- wb_err_i and wb_ack_i asserted together on LHU at 0x2, dat_i 0x8001_0000. Required: bus_err = 1; mem_rdata_mem = 0. Rerun with ack only: mem_rdata_mem = 0x0000_8001.
- Assert reset_n = 0 during REQ. Required: cyc/stb and stall_pipl drop asynchronously; after release the state is IDLE and a fresh SB completes with the correct sel.
